imm_gen_pipe: RTL

Parametrised, pipelined immediate generator for the RISC-V core's decode stage. It covers all RV32I/RV64I immediate formats (I, S, B, J, U, CSR zimm) at a configurable XLEN. A valid/ready handshake with a two-entry skid buffer lets decode stall without dropping or duplicating immediates. Selector codes 00–11 keep the existing I/S/B/J mapping so current control decoders drop in unchanged.

---
 rtl/imm_gen_pipe.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with a valid/ready output register and a skid entry.
// Optional illegal-selector counter port enabled by defining IMM_GEN_ILLEGAL_CNT_EN.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      instr,
    input  logic [SEL_W-1:0] imm_src,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_ext,
    output logic             imm_illegal
`ifdef IMM_GEN_ILLEGAL_CNT_EN
    ,
    output logic [15:0]      illegal_cnt
`endif
);

    typedef enum logic [2:0] {
        SEL_I = 3'd0,
        SEL_S = 3'd1,
        SEL_B = 3'd2,
        SEL_J = 3'd3,
        SEL_U = 3'd4,
        SEL_Z = 3'd5
    } sel_e;

    // Port bit 0 is instruction bit 7; index by architectural bit numbers.
    logic [31:7]     ins;
    sel_e            sel;
    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;

    assign ins = instr;
    assign sel = sel_e'(imm_src);

    always_comb begin
        dec_imm = '0;
        dec_ill = 1'b0;
        case (sel)
            SEL_I: dec_imm = {{(XLEN-12){ins[31]}}, ins[31:20]};
            SEL_S: dec_imm = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
            SEL_B: dec_imm = {{(XLEN-13){ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            SEL_J: dec_imm = {{(XLEN-21){ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            SEL_U: dec_imm = {{(XLEN-31){ins[31]}}, ins[30:12], 12'b0};
            SEL_Z: dec_imm = {{(XLEN-5){1'b0}}, ins[19:15]};
            default: begin
                dec_imm = '0;
                dec_ill = 1'b1;
            end
        endcase
    end

    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d;
    logic            out_ill_q, out_ill_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    logic            skid_ill_q, skid_ill_d;
    logic            accept;
    logic            out_free;

    assign in_ready    = !skid_valid_q;
    assign accept      = in_valid && in_ready;
    assign out_free    = !out_valid_q || out_ready;
    assign out_valid   = out_valid_q;
    assign imm_ext     = out_imm_q;
    assign imm_illegal = out_ill_q;

    // The skid entry always drains before a new input can reach the output, keeping FIFO order.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_ill_d    = out_ill_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_ill_d   = skid_ill_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_ill_d    = skid_ill_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_imm_d   = dec_imm;
                out_ill_d   = dec_ill;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = dec_imm;
            skid_ill_d   = dec_ill;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_ill_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_ill_q    <= out_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

`ifdef IMM_GEN_ILLEGAL_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (accept && dec_ill && (cnt_q != '1)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign illegal_cnt = cnt_q;
`endif

endmodule
